// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement add/sub with carry/borrow-in, carry-out, signed overflow and zero flags.
// Latency STAGES cycles from accept to out_valid; one WIDTH/STAGES-bit carry slice is resolved per stage.
// Valid/ready at both ends; a stalled output holds its value, bubbles are squeezed out, in_ready drops only when every stage is full and stalled.
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Per-stage state: operands travel alongside the partially completed sum so
  // each stage only has to look at its own slice plus the registered carry.
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_c;
  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_sum [STAGES];
  logic              r_ovf;
  logic              r_zero;

  // Stage inputs (what each stage would capture) and computed next values.
  logic [WIDTH-1:0]  w_bp;
  logic              w_c0;
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_src_c;
  logic [WIDTH-1:0]  w_src_a [STAGES];
  logic [WIDTH-1:0]  w_src_b [STAGES];
  logic [WIDTH-1:0]  w_src_s [STAGES];
  logic [WIDTH-1:0]  w_nx_s  [STAGES];
  logic [STAGES-1:0] w_nx_c;
  logic [SW:0]       w_slc;
  logic              w_ovf;
  logic              w_zero;
  logic [STAGES-1:0] w_en;

  // One slice add per stage; the carry into stage k always comes from a register.
  always_comb begin
    w_bp  = sub ? ~b : b;
    w_c0  = sub ? ~cin : cin;
    w_slc = '0;
    w_src_v[0] = in_valid;
    w_src_c[0] = w_c0;
    w_src_a[0] = a;
    w_src_b[0] = w_bp;
    w_src_s[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      w_src_v[k] = r_vld[k-1];
      w_src_c[k] = r_c[k-1];
      w_src_a[k] = r_a[k-1];
      w_src_b[k] = r_b[k-1];
      w_src_s[k] = r_sum[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      w_slc = {1'b0, w_src_a[k][k*SW +: SW]} + {1'b0, w_src_b[k][k*SW +: SW]}
            + {{SW{1'b0}}, w_src_c[k]};
      w_nx_s[k] = w_src_s[k];
      w_nx_s[k][k*SW +: SW] = w_slc[SW-1:0];
      w_nx_c[k] = w_slc[SW];
    end
    // Flags are folded into the last stage register so the outputs stay registered
    // (and read 0 during reset, which a combinational zero-detect would not).
    w_ovf  = (w_src_a[LAST][WIDTH-1] == w_src_b[LAST][WIDTH-1]) &&
             (w_nx_s[LAST][WIDTH-1] != w_src_a[LAST][WIDTH-1]);
    w_zero = (w_nx_s[LAST] == '0);
  end

  // A stage may capture when it or any stage after it is empty, or the output drains;
  // written as a flat OR per stage rather than a rippling chain.
  always_comb begin
    w_en = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_en[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_vld[j]) w_en[k] = 1'b1;
      end
    end
  end

  assign in_ready = w_en[0];

  // Pipeline registers; data only updates when a valid op moves in, so stalled
  // or idle stages keep their contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld  <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_en[k]) begin
          r_vld[k] <= w_src_v[k];
          if (w_src_v[k]) begin
            r_a[k]   <= w_src_a[k];
            r_b[k]   <= w_src_b[k];
            r_sum[k] <= w_nx_s[k];
            r_c[k]   <= w_nx_c[k];
          end
        end
      end
      if (w_en[LAST] && w_src_v[LAST]) begin
        r_ovf  <= w_ovf;
        r_zero <= w_zero;
      end
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_sum[LAST];
  assign cout      = r_c[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
